pool_tile_sequencer: RTL and testbench



---
 rtl/pool_pkg.sv | 35 +++
 rtl/pool_tile_buf.sv | 34 +++
 rtl/pool_tile_sequencer.sv | 149 ++++++++++++++
 tb/tb_pool_tile_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants, index widths and FSM state encoding for the pooling tile sequencer.
package pool_pkg;

    localparam int WIDTH  = 8;
    localparam int TILE   = 25;
    localparam int NOUT   = 4;
    localparam int IDX_W  = 5;
    localparam int OIDX_W = 2;

    localparam logic [IDX_W-1:0]  LAST_IDX  = 5'd24;
    localparam logic [OIDX_W-1:0] LAST_OIDX = 2'd3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Select pooled element sel from the packed result word.
    function automatic logic [WIDTH-1:0] pick_elem(
        input logic [WIDTH*NOUT-1:0] res,
        input logic [OIDX_W-1:0]     sel
    );
        logic [WIDTH-1:0] elem;
        case (sel)
            2'd0:    elem = res[7:0];
            2'd1:    elem = res[15:8];
            2'd2:    elem = res[23:16];
            2'd3:    elem = res[31:24];
            default: elem = res[7:0];
        endcase
        return elem;
    endfunction

endpackage

// File: rtl/pool_tile_buf.sv
// 25-entry pixel register file, written one slot at a time, read out as one flat tile word.
module pool_tile_buf
    import pool_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH*TILE-1:0]   tile
);

    logic [WIDTH-1:0] mem_r [TILE];

    // Slot storage; out-of-range indices are ignored so slot 24 is the last writable one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TILE; k++) begin
                mem_r[k] <= {WIDTH{1'b0}};
            end
        end else if (we && (widx <= LAST_IDX)) begin
            mem_r[widx] <= wdata;
        end
    end

    // Flatten slots so pixel k lands at [8k+7:8k].
    always_comb begin
        tile = {(WIDTH*TILE){1'b0}};
        for (int k = 0; k < TILE; k++) begin
            tile[k*WIDTH +: WIDTH] = mem_r[k];
        end
    end

endmodule

// File: rtl/pool_tile_sequencer.sv
// Tile sequencer: LOAD 25 pixels, WAIT DP_LAT cycles for the datapath, DRAIN 4 result beats.
// Optional completed-tile counter port enabled by defining POOL_TILE_CNT_EN.
module pool_tile_sequencer
    import pool_pkg::*;
#(
    parameter int DP_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        in_data_i,
    output logic [WIDTH*TILE-1:0]   tile_o,
    output logic                    dp_start_o,
    input  logic [WIDTH*NOUT-1:0]   pool_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_last_o
`ifdef POOL_TILE_CNT_EN
    ,
    output logic [15:0]             tile_cnt_o
`endif
);

    localparam logic [3:0] WCNT_INIT = 4'(DP_LAT - 1);

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [OIDX_W-1:0]       oidx_r;
    logic [3:0]              wcnt_r;
    logic [WIDTH*NOUT-1:0]   res_r;
    logic                    out_valid_r;
    logic                    out_last_r;
    logic                    dp_start_r;

    logic                    accept_s;
    logic                    buf_we_s;
    logic                    out_hs_s;
    logic                    final_hs_s;

    assign in_ready_o = (state_r == LOAD) && !rst;
    assign accept_s   = in_valid_i && in_ready_o;
    // A flush in the same cycle as a pixel wins: the pixel is not stored.
    assign buf_we_s   = accept_s && !flush_i;
    assign out_hs_s   = out_valid_r && out_ready_i;
    assign final_hs_s = out_hs_s && (state_r == DRAIN) && (oidx_r == LAST_OIDX) && !flush_i;

    pool_tile_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we_s),
        .widx  (idx_r),
        .wdata (in_data_i),
        .tile  (tile_o)
    );

    // Sequencer FSM with registered handshake/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LOAD;
            idx_r       <= 5'd0;
            oidx_r      <= 2'd0;
            wcnt_r      <= 4'd0;
            res_r       <= {(WIDTH*NOUT){1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            dp_start_r  <= 1'b0;
        end else if (flush_i) begin
            state_r     <= LOAD;
            idx_r       <= 5'd0;
            oidx_r      <= 2'd0;
            wcnt_r      <= 4'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            dp_start_r  <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    dp_start_r <= 1'b0;
                    if (accept_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r    <= WAIT;
                            wcnt_r     <= WCNT_INIT;
                            dp_start_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 5'd1;
                        end
                    end
                end
                WAIT: begin
                    dp_start_r <= 1'b0;
                    if (wcnt_r == 4'd0) begin
                        res_r       <= pool_i;
                        oidx_r      <= 2'd0;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        state_r     <= DRAIN;
                    end else begin
                        wcnt_r <= wcnt_r - 4'd1;
                    end
                end
                DRAIN: begin
                    dp_start_r <= 1'b0;
                    if (final_hs_s) begin
                        state_r     <= LOAD;
                        idx_r       <= 5'd0;
                        oidx_r      <= 2'd0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                    end else if (out_hs_s) begin
                        oidx_r     <= oidx_r + 2'd1;
                        out_last_r <= (oidx_r == 2'd2);
                    end
                end
                default: begin
                    state_r     <= LOAD;
                    idx_r       <= 5'd0;
                    oidx_r      <= 2'd0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    dp_start_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_last_o  = out_last_r;
    assign dp_start_o  = dp_start_r;
    assign out_data_o  = pick_elem(res_r, oidx_r);

`ifdef POOL_TILE_CNT_EN
    logic [15:0] tile_cnt_r;

    // Completed-tile counter; survives flush and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_r <= 16'd0;
        end else if (final_hs_s) begin
            tile_cnt_r <= tile_cnt_r + 16'd1;
        end
    end

    assign tile_cnt_o = tile_cnt_r;
`endif

endmodule

// File: tb/tb_pool_tile_sequencer.sv
// Directed self-checking bench for pool_tile_sequencer (DP_LAT=4 instance).
module tb_pool_tile_sequencer;

    localparam int DPL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_data_i;
    logic [199:0] tile_o;
    logic         dp_start_o;
    logic [31:0]  pool_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [7:0]   out_data_o;
    logic         out_last_o;
`ifdef POOL_TILE_CNT_EN
    logic [15:0]  tile_cnt_o;
    int           exp_cnt = 0;
`endif

    int checks = 0;
    int failures = 0;

    logic        use_manual;
    logic [31:0] pool_manual;
    logic [7:0]  px [25];

    always #5 clk = ~clk;

    // Datapath stand-in: element j is pixel 8, 9, 13, 14 of the tile.
    function automatic logic [31:0] pool_model(input logic [199:0] t);
        return {t[14*8 +: 8], t[13*8 +: 8], t[9*8 +: 8], t[8*8 +: 8]};
    endfunction

    function automatic logic [31:0] manual_word(input int w);
        logic [7:0] w8;
        w8 = 8'(w);
        return {8'h40 + w8, 8'h30 + w8, 8'h20 + w8, 8'h10 + w8};
    endfunction

    assign pool_i = use_manual ? pool_manual : pool_model(tile_o);

    pool_tile_sequencer #(.DP_LAT(DPL)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .tile_o      (tile_o),
        .dp_start_o  (dp_start_o),
        .pool_i      (pool_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o)
`ifdef POOL_TILE_CNT_EN
        ,
        .tile_cnt_o  (tile_cnt_o)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: full tile, 1: flush at drain beat 2, 2: reset during WAIT
    task automatic run_tile(input logic [7:0] base, input bit bubble, input int stall_beat,
                            input int stall_len, input bit manual, input int mode);
        int k, cyc, guard, beat, stalled;
        logic rdy, acc;
        logic [7:0] exp_b [4];
        logic [199:0] exp_tile;
        logic [31:0] mw;
        for (int i = 0; i < 25; i++) begin
            px[i] = base + 8'(i);
            exp_tile[i*8 +: 8] = base + 8'(i);
        end
        use_manual = manual;
        pool_manual = 32'h0;
        k = 0; cyc = 0; guard = 0;
        while (k < 25 && guard < 200) begin
            in_valid_i = (bubble && (guard % 2 == 1)) ? 1'b0 : 1'b1;
            in_data_i = px[k];
            rdy = in_ready_o;
            acc = in_valid_i & rdy;
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL load_ready k=%0d got=%b exp=1", k, rdy);
            end
            tick; guard++; cyc++;
            if (acc) k++;
            checks++;
            if (dp_start_o !== (acc && k == 25)) begin
                failures++;
                $display("FAIL dp_start k=%0d got=%b exp=%b", k, dp_start_o, (acc && k == 25));
            end
        end
        checks++;
        if (k != 25) begin
            failures++;
            $display("FAIL stream_timeout accepted=%0d exp=25", k);
        end
        // Offer a junk pixel while busy; it must never be taken.
        in_valid_i = 1'b1;
        in_data_i = 8'hEE;
        for (int w = 1; w <= DPL; w++) begin
            checks++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || dp_start_o !== (w == 1)) begin
                failures++;
                $display("FAIL wait_state w=%0d valid=%b ready=%b start=%b exp=0,0,%b",
                         w, out_valid_o, in_ready_o, dp_start_o, (w == 1));
            end
            checks++;
            if (tile_o !== exp_tile) begin
                failures++;
                $display("FAIL tile_frozen w=%0d got=%h exp=%h", w, tile_o, exp_tile);
            end
            if (manual) pool_manual = manual_word(w);
            if (mode == 2 && w == 2) begin
                rst = 1'b1;
                tick;
                checks++;
                if (tile_o !== 200'd0 || out_valid_o !== 1'b0 || dp_start_o !== 1'b0 ||
                    out_last_o !== 1'b0 || in_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_wait tile_zero=%b valid=%b start=%b last=%b ready=%b exp=1,0,0,0,0",
                             (tile_o == 200'd0), out_valid_o, dp_start_o, out_last_o, in_ready_o);
                end
`ifdef POOL_TILE_CNT_EN
                exp_cnt = 0;
                checks++;
                if (tile_cnt_o !== 16'd0) begin
                    failures++;
                    $display("FAIL rst_cnt got=%0d exp=0", tile_cnt_o);
                end
`endif
                rst = 1'b0;
                in_valid_i = 1'b0;
                tick;
                checks++;
                if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_release ready=%b valid=%b exp=1,0", in_ready_o, out_valid_o);
                end
                return;
            end
            tick; cyc++;
        end
        mw = manual ? manual_word(DPL) : 32'h0;
        for (int j = 0; j < 4; j++) begin
            exp_b[j] = manual ? mw[j*8 +: 8] : 8'h00;
        end
        if (!manual) begin
            exp_b[0] = px[8]; exp_b[1] = px[9]; exp_b[2] = px[13]; exp_b[3] = px[14];
        end
        beat = 0; stalled = 0; guard = 0;
        while (beat < 4 && guard < 50) begin
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_b[beat] || out_last_o !== (beat == 3)) begin
                failures++;
                $display("FAIL beat%0d valid=%b data=%h last=%b exp=1,%h,%b",
                         beat, out_valid_o, out_data_o, out_last_o, exp_b[beat], (beat == 3));
            end
            checks++;
            if (in_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL drain_ready beat%0d got=%b exp=0", beat, in_ready_o);
            end
            if (mode == 1 && beat == 2) begin
                flush_i = 1'b1;
                out_ready_i = 1'b1;
                tick;
                flush_i = 1'b0;
                in_valid_i = 1'b0;
                checks++;
                if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || in_ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_drain valid=%b last=%b ready=%b exp=0,0,1",
                             out_valid_o, out_last_o, in_ready_o);
                end
                tick;
                checks++;
                if (out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_quiet valid=%b last=%b exp=0,0", out_valid_o, out_last_o);
                end
                return;
            end
            out_ready_i = (beat == stall_beat && stalled < stall_len) ? 1'b0 : 1'b1;
            if (!out_ready_i) stalled++;
            tick; cyc++; guard++;
            if (out_ready_i) beat++;
        end
        in_valid_i = 1'b0;
        checks++;
        if (beat != 4) begin
            failures++;
            $display("FAIL drain_timeout beats=%0d exp=4", beat);
        end
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL drain_end valid=%b ready=%b exp=0,1", out_valid_o, in_ready_o);
        end
        if (!bubble && stall_len == 0) begin
            checks++;
            if (cyc != 29 + DPL) begin
                failures++;
                $display("FAIL tile_period got=%0d exp=%0d", cyc, 29 + DPL);
            end
        end
`ifdef POOL_TILE_CNT_EN
        exp_cnt++;
        checks++;
        if (tile_cnt_o !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL tile_cnt got=%0d exp=%0d", tile_cnt_o, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00;
        out_ready_i = 1'b0; use_manual = 1'b0; pool_manual = 32'h0;
        tick; tick;
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || out_last_o !== 1'b0 ||
            dp_start_o !== 1'b0 || tile_o !== 200'd0) begin
            failures++;
            $display("FAIL reset_state ready=%b valid=%b last=%b start=%b tile_zero=%b exp=0,0,0,0,1",
                     in_ready_o, out_valid_o, out_last_o, dp_start_o, (tile_o == 200'd0));
        end
        rst = 1'b0;
        tick;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b valid=%b exp=1,0", in_ready_o, out_valid_o);
        end
`ifdef POOL_TILE_CNT_EN
        checks++;
        if (tile_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", tile_cnt_o);
        end
`endif
    endtask

    task automatic test_basic;
        run_tile(8'd1, 1'b0, -1, 0, 1'b0, 0);
    endtask

    task automatic test_bubbles_stall;
        run_tile(8'd1, 1'b1, 1, 3, 1'b0, 0);
    endtask

    task automatic test_dp_lat_capture;
        run_tile(8'h20, 1'b0, -1, 0, 1'b1, 0);
        use_manual = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_tile(8'h80, 1'b0, -1, 0, 1'b0, 0);
        run_tile(8'hF0, 1'b0, -1, 0, 1'b0, 0);
    endtask

    task automatic test_flush_load;
        logic [7:0] old12;
        old12 = px[12];
        for (int i = 0; i < 12; i++) begin
            in_valid_i = 1'b1;
            in_data_i = 8'h50 + 8'(i);
            tick;
        end
        in_valid_i = 1'b1;
        in_data_i = 8'hEE;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || dp_start_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_load ready=%b start=%b exp=1,0", in_ready_o, dp_start_o);
        end
        checks++;
        if (tile_o[7:0] !== 8'h50 || tile_o[11*8 +: 8] !== 8'h5B || tile_o[12*8 +: 8] !== old12) begin
            failures++;
            $display("FAIL flush_retain s0=%h s11=%h s12=%h exp=50,5b,%h",
                     tile_o[7:0], tile_o[11*8 +: 8], tile_o[12*8 +: 8], old12);
        end
`ifdef POOL_TILE_CNT_EN
        checks++;
        if (tile_cnt_o !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL flush_cnt got=%0d exp=%0d", tile_cnt_o, exp_cnt);
        end
`endif
        tick;
        run_tile(8'h60, 1'b0, -1, 0, 1'b0, 0);
    endtask

    task automatic test_flush_drain;
        run_tile(8'h30, 1'b0, -1, 0, 1'b0, 1);
`ifdef POOL_TILE_CNT_EN
        checks++;
        if (tile_cnt_o !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL flush_drain_cnt got=%0d exp=%0d", tile_cnt_o, exp_cnt);
        end
`endif
        run_tile(8'h40, 1'b0, -1, 0, 1'b0, 0);
    endtask

    task automatic test_rst_wait;
        run_tile(8'hA0, 1'b0, -1, 0, 1'b0, 2);
        run_tile(8'd1, 1'b0, -1, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles_stall();
        test_dp_lat_capture();
        test_back_to_back();
        test_flush_load();
        test_flush_drain();
        test_rst_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
